// File: rtl/ga_grid_pkg.sv
// Shared configuration-grid constants and the config reader state type.
// Used by logic_grid, the RAM wrapper and the grid config reader.
package ga_grid_pkg;

  localparam int CELL_COUNT = 256;
  localparam int CFG_ADDR_W = 8;
  localparam int CFG_DATA_W = 8;
  localparam int CFG_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/cfg_rd_pipe.sv
// RD_LAT-stage {valid, address} shift register that tracks in-flight RAM reads.
// A flush empties every stage at the next edge.
module cfg_rd_pipe
  import ga_grid_pkg::*;
#(
  parameter int RD_LAT = CFG_RD_LAT,
  parameter int ADDR_W = CFG_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [RD_LAT:0]   valid_chain;
  logic [ADDR_W-1:0] addr_chain [RD_LAT+1];

  assign valid_chain[0] = in_valid;
  assign addr_chain[0]  = in_addr;

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;

    always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
        valid_reg <= 1'b0;
        addr_reg  <= '0;
      end else begin
        valid_reg <= valid_chain[gi];
        addr_reg  <= addr_chain[gi];
      end
    end

    assign valid_chain[gi+1] = valid_reg;
    assign addr_chain[gi+1]  = addr_reg;
  end

  assign out_valid = valid_chain[RD_LAT];
  assign out_addr  = addr_chain[RD_LAT];

endmodule

// File: rtl/logic_grid_config_reader.sv
// Streams the circuit-block genome from the single-port RAM into logic_grid,
// one cell per cycle, with start/busy/done handshake and additive checksum.
module logic_grid_config_reader
  import ga_grid_pkg::*;
#(
  parameter int CELLS  = CELL_COUNT,
  parameter int ADDR_W = CFG_ADDR_W,
  parameter int DATA_W = CFG_DATA_W,
  parameter int RD_LAT = CFG_RD_LAT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [DATA_W-1:0] cell_data,
  output logic              cell_wren,
  output logic              grid_hold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int                 DRAIN_W    = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(CELLS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT);

  cfg_state_t         state_reg, state_next;
  logic [ADDR_W-1:0]  ram_address_reg, ram_address_next;
  logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic [ADDR_W-1:0]  cell_addr_reg, cell_addr_next;
  logic [DATA_W-1:0]  cell_data_reg, cell_data_next;
  logic               cell_wren_reg, cell_wren_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [DATA_W-1:0]  checksum_reg, checksum_next;

  logic              accept;
  logic              abort_load;
  logic              issue_valid;
  logic              last_issue;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic              write_fire;

  assign accept      = (state_reg == IDLE) && start && !abort;
  assign abort_load  = abort && ((state_reg == READ) || (state_reg == DRAIN));
  assign issue_valid = (state_reg == READ);
  assign last_issue  = (ram_address_reg == LAST_ADDR);
  // A read still in flight when abort lands must never reach the grid.
  assign write_fire  = pipe_valid && !abort_load;

  cfg_rd_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (abort_load),
    .in_valid  (issue_valid),
    .in_addr   (ram_address_reg),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = READ;
      end
      READ: begin
        if (abort)           state_next = IDLE;
        else if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (abort)                             state_next = IDLE;
        else if (drain_cnt_reg == DRAIN_LAST)  state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_address_next = '0;
    drain_cnt_next   = '0;
    cell_addr_next   = cell_addr_reg;
    cell_data_next   = cell_data_reg;
    cell_wren_next   = write_fire;
    checksum_next    = checksum_reg;
    busy_next        = (state_next == READ) || (state_next == DRAIN);
    done_next        = (state_next == DONE);

    if ((state_reg == READ) && !abort && !last_issue)
      ram_address_next = ram_address_reg + ADDR_W'(1);

    if (state_reg == DRAIN)
      drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);

    if (write_fire) begin
      cell_addr_next = pipe_addr;
      cell_data_next = ram_q;
    end

    if (accept)
      checksum_next = '0;
    else if (write_fire)
      checksum_next = checksum_reg + ram_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      ram_address_reg <= '0;
      drain_cnt_reg   <= '0;
      cell_addr_reg   <= '0;
      cell_data_reg   <= '0;
      cell_wren_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      checksum_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      ram_address_reg <= ram_address_next;
      drain_cnt_reg   <= drain_cnt_next;
      cell_addr_reg   <= cell_addr_next;
      cell_data_reg   <= cell_data_next;
      cell_wren_reg   <= cell_wren_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      checksum_reg    <= checksum_next;
    end
  end

  assign ram_address = ram_address_reg;
  assign cell_addr   = cell_addr_reg;
  assign cell_data   = cell_data_reg;
  assign cell_wren   = cell_wren_reg;
  assign busy        = busy_reg;
  // The grid stays frozen for exactly the span of a load.
  assign grid_hold   = busy_reg;
  assign done        = done_reg;
  assign checksum    = checksum_reg;

endmodule

// File: tb/tb_logic_grid_config_reader.sv
// Self-checking bench: a RAM model with RD_LAT read latency feeds the reader,
// and a cycle-offset reference model checks every output every cycle.
module tb_logic_grid_config_reader;

  localparam int CELLS    = 256;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int LAT      = 2;
  localparam int LOAD_END = CELLS + LAT;   // last busy cycle of a load

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_q;
  logic [AW-1:0] cell_addr;
  logic [DW-1:0] cell_data;
  logic          cell_wren;
  logic          grid_hold;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  always #5 clock = ~clock;

  logic_grid_config_reader #(
    .CELLS  (CELLS),
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (LAT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .ram_address (ram_address),
    .ram_q       (ram_q),
    .cell_addr   (cell_addr),
    .cell_data   (cell_data),
    .cell_wren   (cell_wren),
    .grid_hold   (grid_hold),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  // RAM model: data for an address appears LAT cycles after it is presented.
  logic [DW-1:0] mem [CELLS];
  logic [AW-1:0] rd_dly [LAT];
  always @(posedge clock) begin
    rd_dly[0] <= ram_address;
    for (int i = 1; i < LAT; i++) rd_dly[i] <= rd_dly[i-1];
  end
  assign ram_q = mem[rd_dly[LAT-1]];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] prefix_sum(input int n);
    logic [DW-1:0] s = '0;
    for (int k = 0; k < n && k < CELLS; k++) s = s + mem[k];
    return s;
  endfunction

  // Reference model: phase = cycle number within the current load, -1 otherwise.
  int            cyc = 0;
  int            phase = -1;
  bit            just_reset = 1'b0;
  bit            chk_known = 1'b1;
  logic [DW-1:0] chk_hold = '0;
  int            accept_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (!reset_n) begin
      phase      <= -1;
      just_reset <= 1'b1;
      chk_known  <= 1'b1;
      chk_hold   <= '0;
    end else begin
      just_reset <= 1'b0;
      if (phase < 0) begin
        if (start && !abort) begin
          phase <= 0;
          accept_q.push_back(cyc + 1);
        end
      end else if (phase <= LOAD_END) begin
        if (abort) begin
          phase     <= -1;
          chk_known <= 1'b0;
        end else begin
          phase <= phase + 1;
        end
      end else begin
        phase     <= -1;
        chk_known <= 1'b1;
        chk_hold  <= prefix_sum(CELLS);
      end
    end
  end

  // Statistics for the pinned expectations.
  int wren_cnt, done_cnt, busy_cnt, hold_cnt, first_wren_cyc, done_cyc;

  always @(negedge clock) begin
    bit exp_busy, exp_done, exp_wren;
    exp_busy = (phase >= 0) && (phase <= LOAD_END);
    exp_done = (phase == LOAD_END + 1);
    exp_wren = (phase >= LAT + 1) && (phase <= LOAD_END);

    if (just_reset) begin
      chk("rst_ram_address", ram_address, 0);
      chk("rst_cell_addr", cell_addr, 0);
      chk("rst_cell_data", cell_data, 0);
    end
    chk("busy", busy, exp_busy);
    chk("grid_hold", grid_hold, exp_busy);
    chk("done", done, exp_done);
    chk("cell_wren", cell_wren, exp_wren);
    if (exp_wren) begin
      chk("cell_addr", cell_addr, phase - LAT - 1);
      chk("cell_data", cell_data, mem[phase - LAT - 1]);
    end
    if (phase >= 0 && phase < CELLS)
      chk("ram_address", ram_address, phase);
    if (phase >= 0)
      chk("checksum_run", checksum, prefix_sum(phase - LAT));
    else if (chk_known)
      chk("checksum_hold", checksum, chk_hold);

    if (cell_wren) begin
      wren_cnt++;
      if (first_wren_cyc < 0) first_wren_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (grid_hold) hold_cnt++;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_stats();
    wren_cnt       = 0;
    done_cnt       = 0;
    busy_cnt       = 0;
    hold_cnt       = 0;
    first_wren_cyc = -1;
    done_cyc       = -1;
    accept_q.delete();
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_cnt < n && t < budget) begin
      tick();
      t++;
    end
    chk("done_within_budget", done_cnt >= n, 1);
  endtask

  task automatic full_load(input string tag, input logic [DW-1:0] exp_sum);
    int c0;
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, 400);
    tick();
    tick();
    c0 = (accept_q.size() > 0) ? accept_q[0] : 0;
    chk({tag, "_wren_count"}, wren_cnt, CELLS);
    chk({tag, "_first_wren"}, first_wren_cyc - c0, 3);
    chk({tag, "_done_cycle"}, done_cyc - c0, 259);
    chk({tag, "_busy_cycles"}, busy_cnt, 259);
    chk({tag, "_hold_cycles"}, hold_cnt, 259);
    chk({tag, "_checksum"}, checksum, exp_sum);
    $display("load %s: writes=%0d done_at=%0d busy=%0d checksum=0x%02h", tag, wren_cnt,
             done_cyc - c0, busy_cnt, checksum);
  endtask

  function automatic logic [DW-1:0] sum_mem();
    logic [DW-1:0] s = '0;
    for (int k = 0; k < CELLS; k++) s = s + mem[k];
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, cut;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    clear_stats();
    for (int k = 0; k < CELLS; k++) mem[k] = 8'(k);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Ramp data: sum 0..255 mod 256 = 0x80
    full_load("ramp", 8'h80);

    // All 0xFF: 256 * 0xFF mod 256 = 0x00
    for (int k = 0; k < CELLS; k++) mem[k] = 8'hFF;
    full_load("all_ff", 8'h00);

    // Abort during cycle 100
    for (int k = 0; k < CELLS; k++) mem[k] = 8'($urandom);
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    clear_stats();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy_c101", busy, 0);
    repeat (300) tick();
    chk("abort_wren_after", wren_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    $display("load abort@100: writes_after=%0d done=%0d", wren_cnt, done_cnt);
    full_load("after_abort", sum_mem());

    // Start held high: back-to-back loads with one idle cycle between
    for (int k = 0; k < CELLS; k++) mem[k] = 8'($urandom);
    clear_stats();
    start = 1'b1;
    wait_done(2, 700);
    start = 1'b0;
    repeat (3) tick();
    chk("b2b_spacing", (accept_q.size() >= 2) ? accept_q[1] - accept_q[0] : 0, 261);
    chk("b2b_wren_count", wren_cnt, 2 * CELLS);
    $display("load back_to_back: loads=%0d writes=%0d", done_cnt, wren_cnt);

    // Reset pulse in cycle 50
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wren", cell_wren, 0);
    chk("rst_mid_checksum", checksum, 0);
    repeat (300) tick();
    chk("rst_mid_no_done", done_cnt, 0);
    $display("load reset@50: done=%0d", done_cnt);

    // start together with abort in IDLE
    clear_stats();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    repeat (5) tick();
    chk("start_abort_busy_cycles", busy_cnt, 0);
    $display("load start+abort: busy_cycles=%0d", busy_cnt);

    // Randomized loads, aborts and resets
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < CELLS; k++) mem[k] = 8'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        full_load("rand_full", sum_mem());
      end else begin
        cut = $urandom_range(0, LOAD_END);
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (cut) tick();
        if (mode == 1) abort = 1'b1;
        else           reset_n = 1'b0;
        tick();
        abort   = 1'b0;
        reset_n = 1'b1;
        repeat (300) tick();
        chk("rand_cut_no_done", done_cnt, 0);
        $display("load rand_%s@%0d: writes=%0d done=%0d", (mode == 1) ? "abort" : "reset",
                 cut, wren_cnt, done_cnt);
      end
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
